// File: rtl/cache_pkg.sv
// Shared geometry, sequencer states and address helpers for the data-cache miss path.
package cache_pkg;

  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int WORDS       = LINE_BYTES / 4;
  localparam int IDX_W       = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_CAP,
    WB_REQ,
    WB_ACK,
    RF_REQ,
    RF_ACK,
    COMMIT
  } state_t;

  // Helpers work on a 64-bit container so any address width up to 64 can use them.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int ofs);
    logic [63:0] mask;
    mask = ~((64'd1 << ofs) - 64'd1);
    return addr & mask;
  endfunction

  function automatic logic [63:0] word_addr(input logic [63:0] base, input int idx);
    return base + (64'(idx) << 2);
  endfunction

endpackage

// File: rtl/cache_word_seq.sv
// Word index sequencer: loadable start index, wrap-around increment, last-word flag.
module cache_word_seq #(
  parameter  int WORDS_P = 8,
  localparam int IW      = $clog2(WORDS_P)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [IW-1:0] start,
  input  logic          advance,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] cnt_q;

  // cnt_q counts words already stepped so "last" is independent of the start index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start;
      cnt_q <= '0;
    end else if (advance) begin
      idx_q <= idx_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == IW'(WORDS_P - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss sequencer: optional dirty-victim writeback, critical-word-first refill with
// store merge, then a single-cycle tag/valid commit.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter  int BLOCK_SIZE = 32,
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  localparam int NWORDS     = BLOCK_SIZE / 4,
  localparam int OFS        = $clog2(BLOCK_SIZE),
  localparam int IW         = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_we,
  input  logic [DATA_W-1:0] miss_wdata,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              wb_rd_en,
  output logic [IW-1:0]     wb_rd_idx,
  input  logic [DATA_W-1:0] wb_rd_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              fill_en,
  output logic [IW-1:0]     fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_tag_we,
  output logic              fill_dirty,
  output logic              miss_done,
  output logic [DATA_W-1:0] miss_rdata,
  output logic              protocol_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, victim_q;
  logic [IW-1:0]     crit_q;
  logic              we_q;
  logic [DATA_W-1:0] store_q, wbdata_q, rdata_q;
  logic              perr_q;

  logic              seq_load, seq_adv, seq_last;
  logic [IW-1:0]     seq_start, seq_idx;
  logic              in_ack;

  assign in_ack = (state_q == WB_ACK) || (state_q == RF_ACK);

  cache_word_seq #(.WORDS_P(NWORDS)) u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (seq_load),
    .start   (seq_start),
    .advance (seq_adv),
    .idx     (seq_idx),
    .last    (seq_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    seq_load      = 1'b0;
    seq_adv       = 1'b0;
    seq_start     = crit_q;
    miss_ready    = 1'b0;
    wb_rd_en      = 1'b0;
    wb_rd_idx     = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_en       = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    fill_tag_we   = 1'b0;
    fill_dirty    = 1'b0;
    miss_done     = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          seq_load  = 1'b1;
          seq_start = victim_dirty ? '0 : miss_addr[OFS-1:2];
          state_d   = victim_dirty ? WB_RD : RF_REQ;
        end
      end
      WB_RD: begin
        wb_rd_en  = 1'b1;
        wb_rd_idx = seq_idx;
        state_d   = WB_CAP;
      end
      WB_CAP: state_d = WB_REQ;
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = ADDR_W'(word_addr(64'(victim_q), int'(seq_idx)));
        mem_req_wdata = wbdata_q;
        if (mem_req_ready) state_d = WB_ACK;
      end
      WB_ACK: begin
        // The refill loop reuses the sequencer, restarting it at the critical word.
        if (mem_resp_valid) begin
          if (seq_last) begin
            seq_load = 1'b1;
            state_d  = RF_REQ;
          end else begin
            seq_adv = 1'b1;
            state_d = WB_RD;
          end
        end
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ADDR_W'(word_addr(64'(base_q), int'(seq_idx)));
        if (mem_req_ready) state_d = RF_ACK;
      end
      RF_ACK: begin
        if (mem_resp_valid) begin
          fill_en   = 1'b1;
          fill_idx  = seq_idx;
          fill_data = (we_q && (seq_idx == crit_q)) ? store_q : mem_resp_rdata;
          if (seq_last) begin
            state_d = COMMIT;
          end else begin
            seq_adv = 1'b1;
            state_d = RF_REQ;
          end
        end
      end
      COMMIT: begin
        fill_tag_we = 1'b1;
        fill_dirty  = we_q;
        miss_done   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, victim word capture, critical-word capture and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      victim_q <= '0;
      crit_q   <= '0;
      we_q     <= 1'b0;
      store_q  <= '0;
      wbdata_q <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && miss_valid) begin
        base_q   <= ADDR_W'(line_base(64'(miss_addr), OFS));
        victim_q <= victim_addr;
        crit_q   <= miss_addr[OFS-1:2];
        we_q     <= miss_we;
        store_q  <= miss_wdata;
      end
      if (state_q == WB_CAP) wbdata_q <= wb_rd_data;
      if (fill_en && (seq_idx == crit_q)) rdata_q <= fill_data;
      if (mem_resp_valid && !in_ack) perr_q <= 1'b1;
    end
  end

  assign miss_rdata   = rdata_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized self-checking bench for cache_refill_ctrl against a transaction-level model.
module tb_cache_refill_ctrl;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic        miss_we = 1'b0;
  logic [31:0] miss_wdata = '0;
  logic        victim_dirty = 1'b0;
  logic [31:0] victim_addr = '0;
  logic        wb_rd_en;
  logic [2:0]  wb_rd_idx;
  logic [31:0] wb_rd_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        fill_en;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_tag_we;
  logic        fill_dirty;
  logic        miss_done;
  logic [31:0] miss_rdata;
  logic        protocol_err;

  cache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_we(miss_we), .miss_wdata(miss_wdata),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .wb_rd_en(wb_rd_en), .wb_rd_idx(wb_rd_idx), .wb_rd_data(wb_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_tag_we(fill_tag_we), .fill_dirty(fill_dirty),
    .miss_done(miss_done), .miss_rdata(miss_rdata), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct packed { logic [2:0] idx; logic [31:0] data; } fill_t;

  int checks = 0;
  int failures = 0;

  req_t  got_req[$], exp_req[$];
  fill_t got_fill[$], exp_fill[$];
  logic [31:0] victim_line [WORDS];

  bit          rand_ready = 0;
  bit          const_mem = 0;
  bit          spurious = 0;
  int          stall_left = 0;
  int          cyc = 0, accepts = 0, dones = 0, commits = 0, accept_cyc = 0, done_cyc = 0, rd_hs = 0;
  logic [31:0] got_rdata = '0;
  logic        got_dirty = 1'b0, got_tag = 1'b0;
  logic [31:0] exp_rdata = '0;
  int          exp_lat = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mem) return 32'h1111_1111;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory, victim-array and observation model; drives at negedge, samples 1ns later.
  initial begin : monitor
    bit          pend;
    bit          stalled;
    logic [31:0] pend_data, wb_pend;
    logic [32:0] held;
    req_t        r;
    fill_t       f;
    pend = 0; stalled = 0; pend_data = '0; wb_pend = '0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin pend = 0; stalled = 0; end
      mem_resp_valid = pend | spurious;
      mem_resp_rdata = pend ? pend_data : 32'hBAD0_BAD0;
      spurious = 0;
      wb_rd_data = wb_pend;
      if (mem_req_valid && !mem_req_we && rd_hs == 2 && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) mem_req_ready = ($urandom_range(0, 2) != 0);
      else mem_req_ready = 1'b1;
      #1;
      pend = 0;
      if (reset_n) begin
        if (miss_valid && miss_ready) begin accepts++; accept_cyc = cyc; end
        if (miss_done) begin
          dones++; done_cyc = cyc;
          got_rdata = miss_rdata; got_dirty = fill_dirty; got_tag = fill_tag_we;
        end
        if (fill_tag_we) commits++;
        if (fill_en) begin f.idx = fill_idx; f.data = fill_data; got_fill.push_back(f); end
        if (wb_rd_en) wb_pend = victim_line[wb_rd_idx];
        if (mem_req_valid) begin
          if (stalled) checkOutput("req_hold", {31'b0, mem_req_we, mem_req_addr}, {31'b0, held});
          if (mem_req_ready) begin
            r.we = mem_req_we; r.addr = mem_req_addr; r.wdata = mem_req_wdata;
            got_req.push_back(r);
            pend = 1; pend_data = mem_word(mem_req_addr);
            if (!mem_req_we) rd_hs++;
            stalled = 0;
          end else if (!stalled) begin
            stalled = 1; held = {mem_req_we, mem_req_addr};
          end
        end
      end
    end
  end

  // Reference model: expected memory traffic, fills, critical word and latency of one miss.
  task automatic build_expect(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic dirty, input logic [31:0] victim, input int stall);
    req_t  r;
    fill_t f;
    int    crit, j;
    logic [31:0] base, a;
    exp_req.delete(); exp_fill.delete();
    crit = int'(addr[4:2]);
    base = addr & ~32'h1F;
    if (dirty)
      for (int k = 0; k < WORDS; k++) begin
        r.we = 1'b1; r.addr = victim + 32'(4 * k); r.wdata = victim_line[k];
        exp_req.push_back(r);
      end
    for (int n = 0; n < WORDS; n++) begin
      j = (crit + n) % WORDS;
      a = base + 32'(4 * j);
      r.we = 1'b0; r.addr = a; r.wdata = '0;
      exp_req.push_back(r);
      f.idx = 3'(j);
      f.data = (we && j == crit) ? wdata : mem_word(a);
      exp_fill.push_back(f);
      if (n == 0) exp_rdata = f.data;
    end
    exp_lat = 1 + 2 * WORDS + (dirty ? 4 * WORDS : 0) + stall;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input logic dirty, input logic [31:0] victim, input bit hold);
    int a0;
    got_req.delete(); got_fill.delete(); rd_hs = 0;
    @(negedge clk);
    miss_valid = 1'b1; miss_addr = addr; miss_we = we; miss_wdata = wdata;
    victim_dirty = dirty; victim_addr = victim;
    a0 = accepts;
    #2;
    for (int t = 0; t < 20 && accepts == a0; t++) begin @(negedge clk); #2; end
    if (accepts == a0) checkOutput("accept_timeout", 64'd0, 64'd1);
    if (!hold) begin @(negedge clk); miss_valid = 1'b0; end
  endtask

  task automatic waitDone(input int d0);
    for (int t = 0; t < 800 && dones == d0; t++) begin @(negedge clk); #2; end
    if (dones == d0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkMiss(input logic dirty_exp, input bit check_lat);
    checkOutput("req_count", 64'(got_req.size()), 64'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && i < got_req.size(); i++) begin
      checkOutput("req_we", 64'(got_req[i].we), 64'(exp_req[i].we));
      checkOutput("req_addr", 64'(got_req[i].addr), 64'(exp_req[i].addr));
      if (exp_req[i].we) checkOutput("req_wdata", 64'(got_req[i].wdata), 64'(exp_req[i].wdata));
    end
    checkOutput("fill_count", 64'(got_fill.size()), 64'(exp_fill.size()));
    for (int i = 0; i < exp_fill.size() && i < got_fill.size(); i++) begin
      checkOutput("fill_idx", 64'(got_fill[i].idx), 64'(exp_fill[i].idx));
      checkOutput("fill_data", 64'(got_fill[i].data), 64'(exp_fill[i].data));
    end
    checkOutput("miss_rdata", 64'(got_rdata), 64'(exp_rdata));
    checkOutput("fill_dirty", 64'(got_dirty), 64'(dirty_exp));
    checkOutput("tag_with_done", 64'(got_tag), 64'd1);
    if (check_lat) checkOutput("latency", 64'(done_cyc - accept_cyc), 64'(exp_lat));
  endtask

  task automatic runMiss(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic dirty, input logic [31:0] victim, input int stall, input bit lat);
    int d0;
    d0 = dones;
    stall_left = stall;
    build_expect(addr, we, wdata, dirty, victim, stall);
    applyStimulus(addr, we, wdata, dirty, victim, 1'b0);
    waitDone(d0);
    checkMiss(we, lat);
  endtask

  initial begin : main
    int d0, a0, c0;
    logic [31:0] ra, rw, rv;
    logic rwe, rd;
    for (int k = 0; k < WORDS; k++) victim_line[k] = 32'hC0DE_0000 + 32'(k);

    #1;
    checkOutput("rst_miss_ready", 64'(miss_ready), 64'd1);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_fill_en", 64'(fill_en), 64'd0);
    checkOutput("rst_done", 64'(miss_done), 64'd0);
    checkOutput("rst_wb_rd_en", 64'(wb_rd_en), 64'd0);
    checkOutput("rst_perr", 64'(protocol_err), 64'd0);
    checkOutput("rst_rdata", 64'(miss_rdata), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] clean load miss crit=5");
    runMiss(32'h0000_1234, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1);

    $display("[TB] dirty miss");
    for (int k = 0; k < WORDS; k++) victim_line[k] = $urandom();
    runMiss(32'h0000_2000, 1'b0, 32'h0, 1'b1, 32'h0000_8000, 0, 1'b1);

    $display("[TB] store miss merge");
    const_mem = 1;
    runMiss(32'h0000_2008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 1'b1);
    const_mem = 0;

    $display("[TB] stalled third refill request");
    runMiss(32'h0000_4014, 1'b0, 32'h0, 1'b0, 32'h0, 5, 1'b1);
    checkOutput("stall_used", 64'(stall_left), 64'd0);

    $display("[TB] random misses");
    for (int i = 0; i < 16; i++) begin
      rand_ready = (i % 2 == 1);
      ra = $urandom(); rwe = 1'($urandom_range(0, 1)); rw = $urandom();
      rd = 1'($urandom_range(0, 1)); rv = $urandom() & ~32'h1F;
      for (int k = 0; k < WORDS; k++) victim_line[k] = $urandom();
      runMiss(ra, rwe, rw, rd, rv, 0, !rand_ready);
    end
    rand_ready = 0;

    $display("[TB] miss_valid held while busy");
    d0 = dones; a0 = accepts;
    build_expect(32'h0000_5000, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    applyStimulus(32'h0000_5000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    miss_addr = 32'h0000_6018; miss_we = 1'b1; miss_wdata = 32'hA5A5_5A5A;
    #1;
    checkOutput("busy_ready", 64'(miss_ready), 64'd0);
    waitDone(d0);
    checkOutput("busy_accepts", 64'(accepts - a0), 64'd1);
    checkMiss(1'b0, 1'b1);
    got_req.delete(); got_fill.delete(); rd_hs = 0;
    build_expect(32'h0000_6018, 1'b1, 32'hA5A5_5A5A, 1'b0, 32'h0, 0);
    d0 = dones;
    for (int t = 0; t < 20 && accepts == a0 + 1; t++) begin @(negedge clk); #2; end
    checkOutput("second_accept", 64'(accepts - a0), 64'd2);
    @(negedge clk);
    miss_valid = 1'b0;
    waitDone(d0);
    checkMiss(1'b1, 1'b1);

    $display("[TB] reset during refill");
    d0 = dones; c0 = commits;
    applyStimulus(32'h0000_7000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #2;
      if (fill_en && fill_idx == 3'd4) break;
    end
    checkOutput("reached_word4", 64'(fill_en && fill_idx == 3'd4), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 64'(miss_ready), 64'd1);
    checkOutput("mid_rst_fill_en", 64'(fill_en), 64'd0);
    checkOutput("mid_rst_req", 64'(mem_req_valid), 64'd0);
    checkOutput("mid_rst_tag", 64'(fill_tag_we), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_commit_after_rst", 64'(commits - c0), 64'd0);
    checkOutput("no_done_after_rst", 64'(dones - d0), 64'd0);
    runMiss(32'h0000_7024, 1'b1, 32'h1357_9BDF, 1'b0, 32'h0, 0, 1'b1);

    $display("[TB] spurious response");
    checkOutput("perr_clear", 64'(protocol_err), 64'd0);
    @(negedge clk); #2;
    spurious = 1;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("perr_set", 64'(protocol_err), 64'd1);
    runMiss(32'h0000_900C, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
    checkOutput("perr_sticky", 64'(protocol_err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
